// File: rtl/comb_equiv_checker.sv
// Exhaustive equivalence checker: sweeps every IN_W-bit vector, holds each for
// SETTLE cycles, and compares all implementation outputs against channel 0.
module comb_equiv_checker #(
   parameter int IN_W     = 4,
   parameter int NUM_IMPL = 4,
   parameter int SETTLE   = 5,
   parameter int ERR_W    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [NUM_IMPL-1:0] impl_out,
   output logic [IN_W-1:0]     stim,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [ERR_W-1:0]    err_count,
   output logic                err_valid,
   output logic [IN_W-1:0]     first_err_vec,
   output logic [NUM_IMPL-1:0] first_err_mask
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int              CNT_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE - 1);
   localparam logic [IN_W-1:0]  STIM_LAST = '1;
   localparam logic [ERR_W-1:0] ERR_MAX   = '1;

   logic [1:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IN_W-1:0]     stim_q, stim_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic [ERR_W-1:0]    err_count_q, err_count_d;
   logic                err_valid_q, err_valid_d;
   logic [IN_W-1:0]     first_err_vec_q, first_err_vec_d;
   logic [NUM_IMPL-1:0] first_err_mask_q, first_err_mask_d;

   // Per-channel disagreement with the reference; channel 0 never disagrees with itself.
   logic [NUM_IMPL-1:0] diff;
   logic                mismatch;
   logic                sample;

   assign diff[0] = 1'b0;

   generate
      for (genvar gi = 1; gi < NUM_IMPL; gi++) begin : g_diff
         assign diff[gi] = impl_out[gi] ^ impl_out[0];
      end
   endgenerate

   assign mismatch = |diff;
   assign sample   = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      stim_d           = stim_q;
      busy_d           = busy_q;
      done_d           = done_q;
      pass_d           = pass_q;
      err_count_d      = err_count_q;
      err_valid_d      = err_valid_q;
      first_err_vec_d  = first_err_vec_q;
      first_err_mask_d = first_err_mask_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d          = ST_RUN;
               cnt_d            = '0;
               stim_d           = '0;
               busy_d           = 1'b1;
               done_d           = 1'b0;
               pass_d           = 1'b0;
               err_count_d      = '0;
               err_valid_d      = 1'b0;
               first_err_vec_d  = '0;
               first_err_mask_d = '0;
            end
         end

         ST_RUN: begin
            if (sample) begin
               if (mismatch) begin
                  if (err_count_q != ERR_MAX) begin
                     err_count_d = err_count_q + ERR_W'(1);
                  end
                  if (!err_valid_q) begin
                     err_valid_d      = 1'b1;
                     first_err_vec_d  = stim_q;
                     first_err_mask_d = diff;
                  end
               end
               // The verdict must include the vector sampled on this same edge.
               if (stim_q == STIM_LAST) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_count_d == '0);
               end else begin
                  stim_d = stim_q + IN_W'(1);
                  cnt_d  = '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= ST_IDLE;
         cnt_q            <= '0;
         stim_q           <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         pass_q           <= 1'b0;
         err_count_q      <= '0;
         err_valid_q      <= 1'b0;
         first_err_vec_q  <= '0;
         first_err_mask_q <= '0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         stim_q           <= stim_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         pass_q           <= pass_d;
         err_count_q      <= err_count_d;
         err_valid_q      <= err_valid_d;
         first_err_vec_q  <= first_err_vec_d;
         first_err_mask_q <= first_err_mask_d;
      end
   end

   assign stim           = stim_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_count_q;
   assign err_valid      = err_valid_q;
   assign first_err_vec  = first_err_vec_q;
   assign first_err_mask = first_err_mask_q;

endmodule

// File: doc/comb_equiv_checker.md
Name: comb_equiv_checker

Overview:
- Synthesizable, parametrised equivalence checker for alternative implementations of one combinational function (structural, dataflow, behavioural, primitive, ...).
- Sweeps every IN_W-bit input vector exhaustively, holding each for SETTLE cycles.
- Compares NUM_IMPL implementation outputs against channel 0, counts mismatches and captures the first failing vector.
- Replaces free-running stimulus plus $monitor checking with a self-checking block usable in simulation and on an FPGA.

Parameters:
- IN_W, 4: width of the stimulus vector; sweep covers 0 .. 2^IN_W-1.
- NUM_IMPL, 4: number of implementation outputs compared; channel 0 is the reference; minimum 2.
- SETTLE, 5: cycles each vector is held before outputs are sampled; minimum 1.
- ERR_W, 8: width of the saturating mismatch counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- impl_out  in  NUM_IMPL  one output bit per implementation; bit 0 is the reference.
- stim  out  IN_W  stimulus vector driven to all implementations.
- busy  out  1  high while a sweep is in progress.
- done  out  1  sticky completion flag; cleared by the next accepted start or by reset.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- err_count  out  ERR_W  number of mismatching vectors; saturates at all-ones.
- err_valid  out  1  high once the first mismatch has been captured.
- first_err_vec  out  IN_W  stim value at the first mismatch.
- first_err_mask  out  NUM_IMPL  bit i set if impl_out[i] != impl_out[0] at the first mismatch; bit 0 is always 0.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - stim, busy, done, pass, err_count, err_valid, first_err_vec, first_err_mask all become 0.
  - A reset mid-sweep aborts the sweep; no partial result is retained.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --last vector sampled--> DONE.
  - DONE --start--> RUN.
  - start during RUN is ignored; it does not restart the sweep or perturb stim.
- Accepting start at edge k:
  - From edge k: busy=1, done=0, pass=0, stim=0, settle counter=0.
  - err_count, err_valid, first_err_vec and first_err_mask clear at the same edge.
- RUN:
  - The settle counter counts 0..SETTLE-1; stim is held constant for exactly SETTLE cycles.
  - impl_out is sampled on the edge where the counter equals SETTLE-1.
  - Mismatch = any impl_out[i] != impl_out[0], for i = 1..NUM_IMPL-1.
  - On a mismatch, err_count increments, saturating at 2^ERR_W-1.
  - On the first mismatch of a sweep only, first_err_vec, first_err_mask and err_valid=1 are loaded.
  - On the same edge as the sample: if stim != all-ones, stim increments and the counter returns to 0; otherwise go to DONE.
- DONE (from the sampling edge of the last vector):
  - busy=0, done=1, pass=(final err_count==0), where the final count includes the last vector's result.
  - stim holds all-ones.
- Timing: busy stays high for exactly SETTLE*2^IN_W cycles.
- Outputs are registered; no combinational path from impl_out to any output.
- Simultaneous rst_n=0 and start: reset wins.

Test Plan:
- Defaults, all four channels driven by the same XOR of stim bits; pulse start -> stim steps 0..15, each value held 5 cycles; busy high 80 cycles; then done=1, pass=1, err_count=0, err_valid=0.
- Channel 2 inverted only when stim=4'hA -> err_count=1, first_err_vec=4'hA, first_err_mask=4'b0100, pass=0.
- Channel 3 inverted on every vector, ERR_W=3 -> err_count saturates at 7; first_err_vec=0, first_err_mask=4'b1000.
- start re-pulsed 20 cycles into a sweep -> ignored, stim sequence and total busy length unchanged; start pulsed in DONE -> restart with all status cleared and stim=0.
- rst_n low for one edge 30 cycles into a sweep -> next cycle all outputs 0, state IDLE; remains IDLE until the next start.
- IN_W=2, SETTLE=1, NUM_IMPL=2 -> stim 0,1,2,3 on consecutive cycles; busy exactly 4 cycles; done asserted on the following cycle.
